hwpq_seq: RTL and testbench

- Upstream stimulus and checker stage for the hardware priority queue (min-queue) in the hwpq_test top level.
- A single-cycle start pulse from the debounced start button begins a run:
  - enqueue a repeatable pseudo-random key sequence from an LFSR;
  - drain the queue;
  - check that popped keys are non-decreasing and that the pop count equals the push count.
- Status goes to the busy LED and the seven-segment display path.

---
 rtl/hwpq_seq.sv | 128 ++++++++++++
 tb/tb_hwpq_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpq_seq.sv
// Stimulus/checker for the min-queue: fills it with LFSR keys, drains it, checks pop ordering and count.
// Latency: one strobe per enq/deq slot; each strobe is registered and followed by a mandatory idle gap cycle.
// Backpressure: holds off every strobe while pq_busy is high; stops filling early on pq_full.
module hwpq_seq #(
   parameter int          KW       = 16,
   parameter int          NUM_KEYS = 8,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          pq_busy,
   input  logic          pq_full,
   input  logic          pq_empty,
   input  logic [KW-1:0] pq_kv_out,
   output logic          pq_enq,
   output logic          pq_deq,
   output logic [KW-1:0] pq_kv_in,
   output logic          busy,
   output logic          done,
   output logic [7:0]    err_count,
   output logic          cnt_err,
   output logic [KW-1:0] last_key
);

   localparam logic [7:0] NUM_KEYS_C = 8'(NUM_KEYS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_FILL_GAP,
      S_DRAIN,
      S_DRAIN_GAP,
      S_DONE
   } state_t;

   state_t      state;
   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;
   logic [7:0]  push_cnt;
   logic [7:0]  pop_cnt;

   // Galois right-shift step, taps 0xB400; only consumed when a key is pushed.
   always_comb begin
      lfsr_nxt = lfsr >> 1;
      if (lfsr[0]) begin
         lfsr_nxt = lfsr_nxt ^ 16'hB400;
      end
   end

   // Run sequencer: all outputs are registered, strobes default low every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pq_enq    <= 1'b0;
         pq_deq    <= 1'b0;
         pq_kv_in  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_count <= 8'd0;
         cnt_err   <= 1'b0;
         last_key  <= '0;
         lfsr      <= SEED;
         push_cnt  <= 8'd0;
         pop_cnt   <= 8'd0;
      end else begin
         pq_enq <= 1'b0;
         pq_deq <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  err_count <= 8'd0;
                  cnt_err   <= 1'b0;
                  done      <= 1'b0;
                  last_key  <= '0;
                  push_cnt  <= 8'd0;
                  pop_cnt   <= 8'd0;
                  lfsr      <= SEED;
                  busy      <= 1'b1;
                  state     <= S_FILL;
               end
            end
            S_FILL: begin
               if ((push_cnt == NUM_KEYS_C) || pq_full) begin
                  state <= S_DRAIN;
               end else if (!pq_busy) begin
                  pq_enq   <= 1'b1;
                  pq_kv_in <= lfsr[KW-1:0];
                  lfsr     <= lfsr_nxt;
                  push_cnt <= push_cnt + 8'd1;
                  state    <= S_FILL_GAP;
               end
            end
            S_FILL_GAP: begin
               // Gives the queue one cycle to raise pq_busy for the enq just issued.
               state <= S_FILL;
            end
            S_DRAIN: begin
               if (pq_busy) begin
                  state <= S_DRAIN;
               end else if (pq_empty) begin
                  cnt_err <= (pop_cnt != push_cnt);
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_DONE;
               end else begin
                  pq_deq   <= 1'b1;
                  pop_cnt  <= pop_cnt + 8'd1;
                  last_key <= pq_kv_out;
                  // The first pop has no predecessor; equal keys are legal.
                  if ((pop_cnt != 8'd0) && (pq_kv_out < last_key) && (err_count != 8'hFF)) begin
                     err_count <= err_count + 8'd1;
                  end
                  state <= S_DRAIN_GAP;
               end
            end
            S_DRAIN_GAP: begin
               state <= S_DRAIN;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hwpq_seq.sv
// Bench for hwpq_seq: behavioural min-queue environment plus a key-list reference model.
// Latency: runs complete within a bounded cycle budget per start.
// Backpressure: environment asserts pq_busy for a configurable number of cycles after each op.
module tb_hwpq_seq;

   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        pq_busy;
   logic        pq_full;
   logic        pq_empty;
   logic [15:0] pq_kv_out;
   logic        pq_enq;
   logic        pq_deq;
   logic [15:0] pq_kv_in;
   logic        busy;
   logic        done;
   logic [7:0]  err_count;
   logic        cnt_err;
   logic [15:0] last_key;

   int tests = 0;
   int fails = 0;

   // environment configuration, written only by the stimulus process between runs
   int cfg_busy_len = 1;
   int cfg_full_lim = 99;
   int cfg_swap     = 0;
   int cfg_drop     = 0;

   // environment state
   logic [15:0] mq[$];
   logic [15:0] push_log[$];
   logic [15:0] pop_log[$];
   int          busy_cnt = 0;
   int          mpops    = 0;
   int          viol     = 0;
   bit          prev_strobe = 1'b0;
   int          pidx;
   int          ipos;

   hwpq_seq #(.KW(16), .NUM_KEYS(4), .SEED(SEED)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pq_busy   (pq_busy),
      .pq_full   (pq_full),
      .pq_empty  (pq_empty),
      .pq_kv_out (pq_kv_out),
      .pq_enq    (pq_enq),
      .pq_deq    (pq_deq),
      .pq_kv_in  (pq_kv_in),
      .busy      (busy),
      .done      (done),
      .err_count (err_count),
      .cnt_err   (cnt_err),
      .last_key  (last_key)
   );

   always #5 clk = ~clk;

   // Behavioural priority queue: sorted list, optional misordering / key loss / early full.
   always @(posedge clk) begin
      if (rst || (start && !busy)) begin
         mq.delete();
         push_log.delete();
         pop_log.delete();
         busy_cnt    = 0;
         mpops       = 0;
         viol        = 0;
         prev_strobe = 1'b0;
      end else begin
         if (pq_enq && pq_deq) viol++;
         if ((pq_enq || pq_deq) && pq_busy) viol++;
         if ((pq_enq || pq_deq) && prev_strobe) viol++;
         prev_strobe = pq_enq || pq_deq;
         if (busy_cnt > 0) busy_cnt--;
         if (pq_enq) begin
            ipos = 0;
            while (ipos < mq.size() && mq[ipos] <= pq_kv_in) ipos++;
            mq.insert(ipos, pq_kv_in);
            push_log.push_back(pq_kv_in);
            busy_cnt = cfg_busy_len;
         end
         if (pq_deq && mq.size() > 0) begin
            pidx = (cfg_swap != 0 && mpops == 1 && mq.size() >= 2) ? 1 : 0;
            pop_log.push_back(mq[pidx]);
            mq.delete(pidx);
            mpops++;
            busy_cnt = cfg_busy_len;
         end
      end
      pidx = (cfg_swap != 0 && mpops == 1 && mq.size() >= 2) ? 1 : 0;
      pq_busy   <= (busy_cnt != 0);
      pq_full   <= (mq.size() >= cfg_full_lim);
      pq_empty  <= (mq.size() == 0) || (cfg_drop != 0 && mpops == cfg_drop);
      pq_kv_out <= (mq.size() > 0) ? mq[pidx] : 16'h0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return (l >> 1) ^ ((l % 2 == 1) ? 16'hB400 : 16'h0000);
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic begin_run(input int bl, input int fl, input int sw, input int dr);
      cfg_busy_len = bl;
      cfg_full_lim = fl;
      cfg_swap     = sw;
      cfg_drop     = dr;
      pulse_start();
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!done && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk("done_wait", 32'(done), 32'd1);
   endtask

   // Expected outcome from the key-list view of a run: LFSR keys, sorted pops, ordering rule.
   task automatic check_run(input string tg, input int fl, input int sw, input int dr);
      logic [15:0] keys[$];
      logic [15:0] srt[$];
      logic [15:0] pops[$];
      logic [15:0] l;
      logic [15:0] t;
      int n;
      int np;
      int ee;
      l  = SEED;
      n  = (fl < 4) ? fl : 4;
      ee = 0;
      for (int i = 0; i < n; i++) begin
         keys.push_back(l);
         l = lfsr_step(l);
      end
      srt = keys;
      srt.sort();
      if (sw != 0 && n >= 3) begin
         t = srt[1];
         srt[1] = srt[2];
         srt[2] = t;
      end
      np = (dr > 0 && dr < n) ? dr : n;
      for (int i = 0; i < np; i++) pops.push_back(srt[i]);
      for (int i = 1; i < np; i++) if (pops[i] < pops[i-1]) ee++;
      wait_done();
      chk({tg, "_npush"}, 32'(push_log.size()), 32'(n));
      for (int i = 0; i < n && i < push_log.size(); i++)
         chk({tg, "_pushkey"}, 32'(push_log[i]), 32'(keys[i]));
      chk({tg, "_npop"}, 32'(pop_log.size()), 32'(np));
      for (int i = 0; i < np && i < pop_log.size(); i++)
         chk({tg, "_popkey"}, 32'(pop_log[i]), 32'(pops[i]));
      chk({tg, "_err_count"}, 32'(err_count), 32'(ee));
      chk({tg, "_cnt_err"}, 32'(cnt_err), 32'(np != n));
      chk({tg, "_last_key"}, 32'(last_key), (np > 0) ? 32'(pops[np-1]) : 32'd0);
      chk({tg, "_busy"}, 32'(busy), 32'd0);
      chk({tg, "_proto"}, 32'(viol), 32'd0);
   endtask

   initial begin
      logic [15:0] exp_push[4];
      logic [15:0] exp_pop[4];
      int k;
      int fl;
      int dr;
      exp_push = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
      exp_pop  = '{16'h389C, 16'h7138, 16'hACE1, 16'hE270};
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_enq_deq", 32'({pq_enq, pq_deq}), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_cnt_err", 32'(cnt_err), 32'd0);
      chk("rst_last_key", 32'(last_key), 32'd0);
      chk("rst_kv_in", 32'(pq_kv_in), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: ideal queue, explicit key values
      begin_run(1, 99, 0, 0);
      chk("t1_busy_running", 32'(busy), 32'd1);
      check_run("t1", 99, 0, 0);
      for (int i = 0; i < 4 && i < push_log.size(); i++) chk("t1_push_const", 32'(push_log[i]), 32'(exp_push[i]));
      for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("t1_pop_const", 32'(pop_log[i]), 32'(exp_pop[i]));
      chk("t1_last_key_const", 32'(last_key), 32'h0000E270);

      // 2: misordering queue
      begin_run(1, 99, 1, 0);
      check_run("t2", 99, 1, 0);
      chk("t2_err_const", 32'(err_count), 32'd1);

      // 5: start pulses in FILL and DRAIN ignored; restart after DONE clears err_count
      begin_run(1, 99, 0, 0);
      chk("t5_err_cleared", 32'(err_count), 32'd0);
      chk("t5_done_cleared", 32'(done), 32'd0);
      pulse_start();
      k = 0;
      while (!pq_deq && k < 200) begin
         @(negedge clk);
         k++;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_run("t5", 99, 0, 0);

      // 3: queue full after two pushes
      begin_run(1, 2, 0, 0);
      check_run("t3", 2, 0, 0);

      // 4: queue loses a key
      begin_run(1, 99, 0, 3);
      check_run("t4", 99, 0, 3);
      chk("t4_cnt_err_const", 32'(cnt_err), 32'd1);

      // 6: reset in DRAIN_GAP (the cycle carrying pq_deq)
      begin_run(1, 99, 0, 0);
      k = 0;
      while (!pq_deq && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t6_saw_deq", 32'(pq_deq), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_strobes", 32'({pq_enq, pq_deq}), 32'd0);
      chk("t6_err_count", 32'(err_count), 32'd0);
      chk("t6_last_key", 32'(last_key), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      begin_run(1, 99, 0, 0);
      check_run("t6_rerun", 99, 0, 0);

      // randomized runs: busy length, full threshold, misordering, key loss, stray starts
      for (int r = 0; r < 10; r++) begin
         fl = $urandom_range(1, 6);
         dr = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
         begin_run($urandom_range(0, 3), fl, $urandom_range(0, 1), dr);
         if ($urandom_range(0, 1) == 1) begin
            pulse_start();
         end
         check_run("rnd", fl, cfg_swap, dr);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
